alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the single rising-edge clock.
REQ-002 The module SHALL have the port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-003 The module SHALL have the port ALUCont, input, 6 bits, the operation select code.
REQ-004 The module SHALL have the port A, input, 32 bits, operand A (two's complement).
REQ-005 The module SHALL have the port B, input, 32 bits, operand B (two's complement).
REQ-006 The module SHALL have the port ALUResult, output, 32 bits, the registered result.
REQ-007 The module SHALL have the port zero, output, 1 bit, the registered flag that is 1 when the result is all-zero.
REQ-008 The module SHALL have the port ovf, output, 1 bit, the registered signed-overflow flag.
REQ-009 The module SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n); no other clocks or resets SHALL exist.

Function
REQ-010 The module SHALL decode ALUCont as follows: 6'b000000=AND, 6'b000001=OR, 6'b000010=ADD, 6'b000110=SUB, 6'b000111=SLT, 6'b001100=NOR.
REQ-011 The module SHALL compute AND as A & B, OR as A | B, and NOR as ~(A | B), bitwise over 32 bits.
REQ-012 The module SHALL compute ADD as A + B and SUB as A - B, modulo 2^32, with the carry/borrow discarded.
REQ-013 SLT SHALL produce 32'h00000001 when signed(A) < signed(B) and 32'h00000000 otherwise; equal operands SHALL give 0.
REQ-014 ovf SHALL be 1 for ADD only when A[31]==B[31] and sum[31]!=A[31].
REQ-015 ovf SHALL be 1 for SUB only when A[31]!=B[31] and diff[31]!=A[31].
REQ-016 ovf SHALL be 0 for all other operations, including SLT.
REQ-017 SLT SHALL be correct even when A - B overflows; it SHALL use diff[31] XOR the overflow condition.
REQ-018 An undefined ALUCont code SHALL produce ALUResult=0, zero=1 and ovf=0.
REQ-019 zero SHALL equal (next ALUResult == 0) and SHALL be registered in the same cycle as ALUResult.
REQ-020 Latency SHALL be 1 cycle: operands and ALUCont sampled at rising edge N SHALL appear on the outputs after edge N.
REQ-021 The module SHALL accept a new operation every cycle, with no handshake and no stall.
REQ-022 The outputs SHALL hold their values between clock edges; input changes between edges SHALL have no effect on the outputs.

Reset
REQ-023 While rst_n=0, ALUResult=0, zero=0 and ovf=0 SHALL hold immediately, independent of clk.
REQ-024 Reset asserted mid-stream SHALL discard any pending result.
REQ-025 The first valid result after reset release SHALL appear after the first rising edge with rst_n=1.

Structure
REQ-026 The six opcode constants SHALL be defined in a shared package alu_pkg, and that package SHALL be used by both the RTL and the bench.
REQ-027 The add/subtract path SHALL be implemented in one sub-module alu_addsub (inputs A, B, sub; outputs 32-bit result and ovf), which SHALL be shared by ADD, SUB and SLT.
REQ-028 The result mux and the output registers SHALL reside in alu; there SHALL be no state besides the three output registers.

Verification
REQ-029 With A=11111111, B=22222222 and ops ADD/SUB/SLT/AND/OR/NOR, the bench SHALL check results 33333333/EEEEEEEF/00000001/00000000/33333333/CCCCCCCC, zero=1 only for AND, and ovf=0 throughout.
REQ-030 With A=BEEFFEEB, B=DEADDEAD and ops ADD/SUB/SLT/AND/OR/NOR, the bench SHALL check results 9D9DDD98/E042203E/00000001/9EADDEA9/FEEFFEEF/01100110, with ovf=0 throughout.
REQ-031 The bench SHALL check overflow: ADD 7FFFFFFF+00000001 gives 80000000 with ovf=1; SUB 80000000-00000001 gives 7FFFFFFF with ovf=1; SLT with A=80000000, B=00000001 gives 00000001.
REQ-032 The bench SHALL check the SLT edges: equal operands 12345678,12345678 give 0 with zero=1; A=FFFFFFFF, B=00000000 gives 00000001.
REQ-033 The bench SHALL check reset: asserting rst_n=0 between edges while outputs are non-zero clears ALUResult, zero and ovf to 0 without waiting for a clock edge; after release, the first edge produces the correct result.
REQ-034 The bench SHALL check an undefined code: ALUCont=6'b111111 gives ALUResult=0, zero=1, ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode definitions and small decode helpers for the ALU and its bench.
package alu_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned OpWidth   = 6;

    typedef enum logic [OpWidth-1:0] {
        OpAnd = 6'b000000,
        OpOr  = 6'b000001,
        OpAdd = 6'b000010,
        OpSub = 6'b000110,
        OpSlt = 6'b000111,
        OpNor = 6'b001100
    } alu_op_e;

    // SUB and SLT both need A - B from the shared adder.
    function automatic logic op_uses_sub(input logic [OpWidth-1:0] op);
        return (op == OpSub) || (op == OpSlt);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared two's-complement adder/subtractor with signed-overflow detection.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [DataWidth-1:0] A,
    input  logic [DataWidth-1:0] B,
    input  logic                 sub,
    output logic [DataWidth-1:0] result,
    output logic                 ovf
);

    logic [DataWidth-1:0] b_eff;

    always_comb begin
        b_eff  = sub ? ~B : B;
        result = A + b_eff + {{(DataWidth-1){1'b0}}, sub};
        // Overflow when the effective operands agree in sign but the result does not.
        ovf    = (A[DataWidth-1] == b_eff[DataWidth-1]) &&
                 (result[DataWidth-1] != A[DataWidth-1]);
    end

endmodule

// File: rtl/alu.sv
// Single-cycle-latency ALU: combinational result mux feeding three output registers.
module alu
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OpWidth-1:0]   ALUCont,
    input  logic [DataWidth-1:0] A,
    input  logic [DataWidth-1:0] B,
    output logic [DataWidth-1:0] ALUResult,
    output logic                 zero,
    output logic                 ovf
);

    logic [DataWidth-1:0] as_result;
    logic                 as_ovf;
    logic                 as_sub;

    logic [DataWidth-1:0] result_d, result_q;
    logic                 zero_d, zero_q;
    logic                 ovf_d, ovf_q;

    assign as_sub = op_uses_sub(ALUCont);

    alu_addsub u_addsub (
        .A      (A),
        .B      (B),
        .sub    (as_sub),
        .result (as_result),
        .ovf    (as_ovf)
    );

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        unique case (ALUCont)
            OpAnd: result_d = A & B;
            OpOr:  result_d = A | B;
            OpNor: result_d = ~(A | B);
            OpAdd: begin
                result_d = as_result;
                ovf_d    = as_ovf;
            end
            OpSub: begin
                result_d = as_result;
                ovf_d    = as_ovf;
            end
            // Sign of A - B corrected by overflow gives the true signed comparison.
            OpSlt: result_d = {{(DataWidth-1){1'b0}}, as_result[DataWidth-1] ^ as_ovf};
            default: ;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ALUResult = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for the registered ALU.
module tb_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  ALUCont;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        zero;
    logic        ovf;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total;
    int    passed;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUCont   (ALUCont),
        .A         (A),
        .B         (B),
        .ALUResult (ALUResult),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    endtask

    // Drive one operation away from the active edge and record what it must produce.
    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic z, input logic v,
                         input string tag);
        exp_t e;
        @(negedge clk);
        ALUCont = op;
        A       = a;
        B       = b;
        e.res   = res;
        e.z     = z;
        e.v     = v;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  e;
        string tag;
        @(posedge clk);
        #1;
        total++;
        assert (exp_q.size() > 0) passed++;
        else $error("FAIL scoreboard: got empty queue, expected pending entry");
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            chk32({tag, " res"}, ALUResult, e.res);
            chk1({tag, " zero"}, zero, e.z);
            chk1({tag, " ovf"}, ovf, e.v);
        end
    endtask

    task automatic op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic z, input logic v,
                      input string tag);
        drive(o, a, b, res, z, v, tag);
        check_out();
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        rst_n   = 1'b0;
        ALUCont = OpAnd;
        A       = 32'hFFFF_FFFF;
        B       = 32'hFFFF_FFFF;
        #1;
        chk32("reset res", ALUResult, 32'h0);
        chk1("reset zero", zero, 1'b0);
        chk1("reset ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        chk32("reset held res", ALUResult, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        op(OpAdd, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0, "p1 add");
        op(OpSub, 32'h11111111, 32'h22222222, 32'hEEEEEEEF, 1'b0, 1'b0, "p1 sub");
        op(OpSlt, 32'h11111111, 32'h22222222, 32'h00000001, 1'b0, 1'b0, "p1 slt");
        op(OpAnd, 32'h11111111, 32'h22222222, 32'h00000000, 1'b1, 1'b0, "p1 and");
        op(OpOr,  32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0, "p1 or");
        op(OpNor, 32'h11111111, 32'h22222222, 32'hCCCCCCCC, 1'b0, 1'b0, "p1 nor");

        op(OpAdd, 32'hBEEFFEEB, 32'hDEADDEAD, 32'h9D9DDD98, 1'b0, 1'b0, "p2 add");
        op(OpSub, 32'hBEEFFEEB, 32'hDEADDEAD, 32'hE042203E, 1'b0, 1'b0, "p2 sub");
        op(OpSlt, 32'hBEEFFEEB, 32'hDEADDEAD, 32'h00000001, 1'b0, 1'b0, "p2 slt");
        op(OpAnd, 32'hBEEFFEEB, 32'hDEADDEAD, 32'h9EADDEA9, 1'b0, 1'b0, "p2 and");
        op(OpOr,  32'hBEEFFEEB, 32'hDEADDEAD, 32'hFEEFFEEF, 1'b0, 1'b0, "p2 or");
        op(OpNor, 32'hBEEFFEEB, 32'hDEADDEAD, 32'h01100110, 1'b0, 1'b0, "p2 nor");

        op(OpAdd, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, "ovf add");
        op(OpSub, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, "ovf sub");
        op(OpSlt, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, "ovf slt");
        op(OpSlt, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, "ovf slt rev");
        op(OpSlt, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, "slt equal");
        op(OpSlt, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, "slt neg");
        op(6'b111111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, "undef op");
        op(OpSub, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 1'b1, 1'b0, "sub zero");

        // Back-to-back stream: one new op every cycle.
        drive(OpAdd, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0, 1'b0, "str add");
        check_out();
        drive(OpOr, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0, "str or");
        check_out();

        // Outputs hold while inputs change between edges.
        ALUCont = OpNor;
        A       = 32'h0;
        B       = 32'h0;
        #2;
        chk32("hold res", ALUResult, 32'hF000000F);
        chk1("hold zero", zero, 1'b0);

        // Leave non-zero outputs with ovf set, then reset mid-cycle.
        op(OpAdd, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, "pre rst");
        @(negedge clk);
        ALUCont = OpAdd;
        A       = 32'h1;
        B       = 32'h1;
        #1;
        rst_n = 1'b0;
        #1;
        chk32("async rst res", ALUResult, 32'h0);
        chk1("async rst zero", zero, 1'b0);
        chk1("async rst ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        chk32("rst pending dropped", ALUResult, 32'h0);
        chk1("rst pending ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        op(OpSub, 32'h00000010, 32'h00000003, 32'h0000000D, 1'b0, 1'b0, "post rst");

        total++;
        assert (exp_q.size() == 0) passed++;
        else $error("FAIL scoreboard drain: got %0d left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
